// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: default timing parameters,
// response-slot layout and the burst-alignment helper.
package mem_pkg;

    localparam int LATENCY_DEF   = 4;
    localparam int BURST_LEN_DEF = 4;
    localparam int ADDR_W        = 16;
    localparam int DATA_W        = 16;

    typedef struct packed {
        logic              valid;
        logic              last;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } rsp_slot_t;

    // Clears the in-block word offset and the byte bit, giving the first beat's address.
    function automatic logic [ADDR_W-1:0] burst_base(input logic [ADDR_W-1:0] addr,
                                                     input int                burst_len);
        logic [ADDR_W-1:0] mask;
        mask = ADDR_W'(2 * burst_len - 1);
        return addr & ~mask;
    endfunction

endpackage

// File: rtl/mem_rsp_pipe.sv
// Fixed-depth delay line for response slots; every stage is cleared by reset so
// nothing in flight survives it.
module mem_rsp_pipe
    import mem_pkg::*;
#(
    parameter int DEPTH = LATENCY_DEF - 1
) (
    input  logic      clk,
    input  logic      rst_n,
    input  rsp_slot_t slot_in,
    output rsp_slot_t slot_out
);

    rsp_slot_t stage_reg [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        rsp_slot_t stage_d;

        if (gi == 0) begin : g_head
            assign stage_d = slot_in;
        end else begin : g_tail
            assign stage_d = stage_reg[gi-1];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stage_reg[gi] <= '0;
            end else begin
                stage_reg[gi] <= stage_d;
            end
        end
    end

    assign slot_out = stage_reg[DEPTH-1];

endmodule

// File: rtl/mem_responder.sv
// Memory end of the CPU request interface: word array, single/burst read issue
// FSM and an in-order fixed-latency response pipe.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_W   = 10,
    parameter int LATENCY   = LATENCY_DEF,
    parameter int BURST_LEN = BURST_LEN_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_en,
    input  logic        req_wr,
    input  logic        req_burst,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic [15:0] rsp_addr,
    output logic        rsp_last
);

    localparam int WORDS  = 1 << DEPTH_W;
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [0:0]        ST_IDLE   = 1'b0;
    localparam logic [0:0]        ST_BURST  = 1'b1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    logic [DATA_W-1:0] mem_array [WORDS];

    logic [0:0]        state_reg, state_next;
    logic [BEAT_W-1:0] beat_reg, beat_next;
    logic [ADDR_W-1:0] base_reg, base_next;

    logic              accept;
    logic              issue;
    logic              issue_last;
    logic [ADDR_W-1:0] issue_addr;
    logic [DEPTH_W-1:0] wr_idx, rd_idx;

    logic              head_valid_reg;
    logic              head_last_reg;
    logic [ADDR_W-1:0] head_addr_reg;
    logic [DATA_W-1:0] rd_data_reg;
    rsp_slot_t         head_slot, tail_slot;

    assign req_ready = (state_reg == ST_IDLE);
    assign accept    = req_en & req_ready;

    always_comb begin
        state_next = state_reg;
        beat_next  = beat_reg;
        base_next  = base_reg;
        issue      = 1'b0;
        issue_last = 1'b1;
        issue_addr = {req_addr[ADDR_W-1:1], 1'b0};
        if (state_reg == ST_IDLE) begin
            if (accept && !req_wr) begin
                issue = 1'b1;
                if (req_burst && (BURST_LEN > 1)) begin
                    base_next  = burst_base(req_addr, BURST_LEN);
                    issue_addr = base_next;
                    issue_last = 1'b0;
                    beat_next  = BEAT_W'(1);
                    state_next = ST_BURST;
                end
            end
        end else begin
            // Beats always ascend from the aligned base; no critical-word-first.
            issue      = 1'b1;
            issue_addr = base_reg + ADDR_W'({beat_reg, 1'b0});
            issue_last = (beat_reg == LAST_BEAT);
            beat_next  = beat_reg + 1'b1;
            if (issue_last) begin
                state_next = ST_IDLE;
            end
        end
    end

    assign wr_idx = req_addr[DEPTH_W:1];
    assign rd_idx = issue_addr[DEPTH_W:1];

    // Array port kept reset-free so it maps onto block RAM with a registered read.
    always_ff @(posedge clk) begin
        if (accept && req_wr) begin
            mem_array[wr_idx] <= req_wdata;
        end
        rd_data_reg <= mem_array[rd_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            beat_reg       <= '0;
            base_reg       <= '0;
            head_valid_reg <= 1'b0;
            head_last_reg  <= 1'b0;
            head_addr_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            beat_reg       <= beat_next;
            base_reg       <= base_next;
            head_valid_reg <= issue;
            head_last_reg  <= issue & issue_last;
            head_addr_reg  <= issue_addr;
        end
    end

    assign head_slot = '{valid: head_valid_reg, last: head_last_reg,
                         addr: head_addr_reg, data: rd_data_reg};

    if (LATENCY > 1) begin : g_pipe
        mem_rsp_pipe #(
            .DEPTH (LATENCY - 1)
        ) u_rsp_pipe (
            .clk      (clk),
            .rst_n    (rst_n),
            .slot_in  (head_slot),
            .slot_out (tail_slot)
        );
    end else begin : g_direct
        // The read register has no reset, so mask its data while the slot is empty.
        always_comb begin
            tail_slot = head_slot;
            if (!head_slot.valid) begin
                tail_slot.data = '0;
            end
        end
    end

    assign rsp_valid = tail_slot.valid;
    assign rsp_last  = tail_slot.last;
    assign rsp_addr  = tail_slot.addr;
    assign rsp_data  = tail_slot.data;

endmodule
